// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master/two-slave shared bus with M0 priority, address decode and 1-cycle read return.
// Optional BUS_TIMEOUT_EN bounds M1 ownership to TIMEOUT cycles while M0 is waiting.
module bus_arbiter #(
    parameter int                ADDR_W  = 8,
    parameter int                DATA_W  = 32,
    parameter logic [ADDR_W-1:0] S0_BASE = 8'h00,
    parameter logic [ADDR_W-1:0] S1_BASE = 8'h20,
    parameter int                TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              M0_req,
    input  logic              M0_wr,
    input  logic [ADDR_W-1:0] M0_address,
    input  logic [DATA_W-1:0] M0_dout,
    input  logic              M1_req,
    input  logic              M1_wr,
    input  logic [ADDR_W-1:0] M1_address,
    input  logic [DATA_W-1:0] M1_dout,
    input  logic [DATA_W-1:0] S0_dout,
    input  logic [DATA_W-1:0] S1_dout,
    output logic              M0_grant,
    output logic              M1_grant,
    output logic [ADDR_W-1:0] S_address,
    output logic [DATA_W-1:0] S_din,
    output logic              S_wr,
    output logic              S0_sel,
    output logic              S1_sel,
    output logic [DATA_W-1:0] M_din
);
    typedef enum logic {GNT_M0, GNT_M1} state_t;
    state_t     state, state_next;
    logic [1:0] rd_sel;
    logic       timeout_hit;
`ifdef BUS_TIMEOUT_EN
    logic [7:0] cnt;
    // Saturates at TIMEOUT-1 so a late M0 request still forces the handover.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                   cnt <= '0;
        else if (state != GNT_M1)       cnt <= '0;
        else if (cnt != 8'(TIMEOUT-1))  cnt <= cnt + 8'd1;
    end
    assign timeout_hit = (state == GNT_M1) && (cnt == 8'(TIMEOUT-1)) && M0_req;
`else
    assign timeout_hit = 1'b0 && (TIMEOUT > 0);
`endif
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= GNT_M0;
            rd_sel <= 2'b00;
        end else begin
            state  <= state_next;
            rd_sel <= {S1_sel, S0_sel};
        end
    end
    always_comb begin
        state_next = state;
        if (state == GNT_M0) state_next = (!M0_req && M1_req) ? GNT_M1 : GNT_M0;
        else                 state_next = (M1_req && !timeout_hit) ? GNT_M1 : GNT_M0;
    end
    assign M0_grant  = (state == GNT_M0);
    assign M1_grant  = (state == GNT_M1);
    assign S_address = M1_grant ? M1_address : M0_address;
    assign S_din     = M1_grant ? M1_dout : M0_dout;
    assign S_wr      = M1_grant ? M1_wr : M0_wr;
    assign S0_sel    = (S_address[ADDR_W-1 -: 3] == S0_BASE[ADDR_W-1 -: 3]);
    assign S1_sel    = (S_address[ADDR_W-1 -: 3] == S1_BASE[ADDR_W-1 -: 3]) && !S0_sel;
    assign M_din     = (rd_sel == 2'b01) ? S0_dout : (rd_sel == 2'b10) ? S1_dout : '0;
endmodule
